updi_phy_link: RTL

Physical-layer stage directly downstream of the UPDI instruction queue handler. Drains bytes from the shared command FIFO and serialises them onto the single-wire UPDI line as UART frames: 1 start bit, 8 data bits LSB first, even parity, 2 stop bits. When the queue handler raises `waiting_for_ack` and the FIFO is empty, the block releases the line, receives one frame from the target, and reports ACK (0x40) or failure back to the handler.

---
 rtl/updi_phy_link_if.sv | 28 ++
 rtl/updi_phy_link.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/updi_phy_link_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | updi_phy_link_if: FIFO, handler and line signals of the UPDI PHY    |
// | Revision: 1.0                                                       |
// +--------------------------------------------------------------------+
interface updi_phy_link_if;
  logic [7:0] fifo_out;
  logic       fifo_empty;
  logic       fifo_rd_en;
  logic       waiting_for_ack;
  logic       ack_received;
  logic       ack_error;
  logic       updi_rx;
  logic       updi_tx;
  logic       updi_oe;
  logic       busy;

  modport master (
    input  fifo_out, fifo_empty, waiting_for_ack, updi_rx,
    output fifo_rd_en, ack_received, ack_error, updi_tx, updi_oe, busy
  );

  modport slave (
    output fifo_out, fifo_empty, waiting_for_ack, updi_rx,
    input  fifo_rd_en, ack_received, ack_error, updi_tx, updi_oe, busy
  );
endinterface
`default_nettype wire

// File: rtl/updi_phy_link.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | updi_phy_link: serialises FIFO bytes as 8E2 UPDI frames, takes ACK  |
// | Revision: 1.0                                                       |
// +--------------------------------------------------------------------+
module updi_phy_link #(
  parameter int CLKS_PER_BIT    = 16,
  parameter int RX_TIMEOUT_BITS = 64
) (
  input  logic               clk,
  input  logic               rst,
  updi_phy_link_if.master    bus
);
  localparam int TO_LIMIT = RX_TIMEOUT_BITS * CLKS_PER_BIT;
  localparam int TO_W     = $clog2(TO_LIMIT + 1);
  localparam int CW       = $clog2(CLKS_PER_BIT + 1);
  localparam logic [CW-1:0]   CNT_BIT  = CW'(CLKS_PER_BIT);
  localparam logic [CW-1:0]   CNT_HALF = CW'(CLKS_PER_BIT / 2);
  localparam logic [CW-1:0]   CNT_ONE  = CW'(1);
  localparam logic [TO_W-1:0] TO_END   = TO_W'(TO_LIMIT);

  typedef enum logic [2:0] {
    IDLE, FETCH, LOAD, TX, RX_WAIT, RX_BITS, HOLDOFF
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [3:0]      bit_q, bit_d;
  logic [11:0]     tx_sh_q, tx_sh_d;
  logic [9:0]      rx_sh_q, rx_sh_d;
  logic [TO_W-1:0] to_q, to_d;
  logic            hunt_q, hunt_d;
  logic            rx_s1_q, rx_s1_d, rx_s2_q, rx_s2_d, rx_prev_q, rx_prev_d;
  logic            fifo_rd_en_q, fifo_rd_en_d;
  logic            ack_rx_q, ack_rx_d, ack_err_q, ack_err_d;
  logic            tx_q, tx_d, oe_q, oe_d;
  logic            fall;

  assign fall = rx_prev_q & ~rx_s2_q;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    bit_d        = bit_q;
    tx_sh_d      = tx_sh_q;
    rx_sh_d      = rx_sh_q;
    to_d         = to_q;
    hunt_d       = hunt_q;
    rx_s1_d      = bus.updi_rx;
    rx_s2_d      = rx_s1_q;
    rx_prev_d    = rx_s2_q;
    fifo_rd_en_d = 1'b0;
    ack_rx_d     = 1'b0;
    ack_err_d    = 1'b0;
    tx_d         = tx_q;
    oe_d         = oe_q;
    case (state_q)
      IDLE: begin
        cnt_d  = '0;
        bit_d  = '0;
        to_d   = '0;
        hunt_d = 1'b0;
        if (!bus.fifo_empty) begin
          state_d      = FETCH;
          fifo_rd_en_d = 1'b1;
        end else if (bus.waiting_for_ack) begin
          state_d = RX_WAIT;
        end
      end
      FETCH: state_d = LOAD;
      LOAD: begin
        tx_sh_d = {2'b11, ^bus.fifo_out, bus.fifo_out, 1'b0};
        tx_d    = 1'b0;
        oe_d    = 1'b1;
        cnt_d   = CNT_ONE;
        bit_d   = '0;
        state_d = TX;
      end
      TX: begin
        if (cnt_q == CNT_BIT) begin
          cnt_d = CNT_ONE;
          if (bit_q == 4'd11) begin
            state_d = IDLE;
            tx_d    = 1'b1;
            oe_d    = 1'b0;
          end else begin
            bit_d   = bit_q + 4'd1;
            tx_sh_d = {1'b1, tx_sh_q[11:1]};
            tx_d    = tx_sh_q[1];
          end
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      RX_WAIT: begin
        to_d = to_q + 1'b1;
        if (!bus.waiting_for_ack) begin
          state_d = IDLE;
        end else if (to_d == TO_END) begin
          ack_err_d = 1'b1;
          cnt_d     = '0;
          state_d   = HOLDOFF;
        end else if (hunt_q) begin
          // Confirm the start bit half a bit after the edge; a high line is a glitch.
          if (cnt_q == CNT_HALF) begin
            hunt_d = 1'b0;
            if (!rx_s2_q) begin
              state_d = RX_BITS;
              cnt_d   = CNT_ONE;
              bit_d   = '0;
            end
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end else if (fall) begin
          hunt_d = 1'b1;
          cnt_d  = CNT_ONE;
        end
      end
      RX_BITS: begin
        if (cnt_q == CNT_BIT) begin
          rx_sh_d = {rx_s2_q, rx_sh_q[9:1]};
          cnt_d   = CNT_ONE;
          bit_d   = bit_q + 4'd1;
          if (bit_q == 4'd9) begin
            cnt_d   = '0;
            state_d = HOLDOFF;
            if (rx_sh_d[7:0] == 8'h40 && !(^rx_sh_d[8:0]) && rx_sh_d[9])
              ack_rx_d = 1'b1;
            else
              ack_err_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      HOLDOFF: begin
        if (cnt_q == CNT_ONE) state_d = IDLE;
        else                  cnt_d   = cnt_q + CNT_ONE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      bit_q        <= '0;
      tx_sh_q      <= '0;
      rx_sh_q      <= '0;
      to_q         <= '0;
      hunt_q       <= 1'b0;
      rx_s1_q      <= 1'b1;
      rx_s2_q      <= 1'b1;
      rx_prev_q    <= 1'b1;
      fifo_rd_en_q <= 1'b0;
      ack_rx_q     <= 1'b0;
      ack_err_q    <= 1'b0;
      tx_q         <= 1'b1;
      oe_q         <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      bit_q        <= bit_d;
      tx_sh_q      <= tx_sh_d;
      rx_sh_q      <= rx_sh_d;
      to_q         <= to_d;
      hunt_q       <= hunt_d;
      rx_s1_q      <= rx_s1_d;
      rx_s2_q      <= rx_s2_d;
      rx_prev_q    <= rx_prev_d;
      fifo_rd_en_q <= fifo_rd_en_d;
      ack_rx_q     <= ack_rx_d;
      ack_err_q    <= ack_err_d;
      tx_q         <= tx_d;
      oe_q         <= oe_d;
    end
  end

  assign bus.fifo_rd_en   = fifo_rd_en_q;
  assign bus.ack_received = ack_rx_q;
  assign bus.ack_error    = ack_err_q;
  assign bus.updi_tx      = tx_q;
  assign bus.updi_oe      = oe_q;
  assign bus.busy         = (state_q != IDLE);
endmodule
`default_nettype wire
